// File: rtl/nibble_bus_ctrl_if.sv
// Request handshake and per-register bus control lines for nibble_bus_ctrl.
// master = instruction decode side, slave = the transfer sequencer.
interface nibble_bus_ctrl_if #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    req_src;
  logic [SEL_W-1:0]    req_dst;
  logic [NUM_REGS-1:0] out_en_n;
  logic [NUM_REGS-1:0] load;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, out_en_n, load, busy, done, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, out_en_n, load, busy, done, err
  );
endinterface

// File: rtl/nibble_bus_ctrl.sv
// Contention-free move sequencer for a shared 4-bit tri-state register bus.
// Define NBC_TURNAROUND_EN to add a dead bus cycle (GAP) after each transfer.
module nibble_bus_ctrl #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input logic              clk,
  input logic              reset,
  nibble_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StDrive, StLoad, StHold, StDone, StGap} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    src_q, src_d;
  logic [SEL_W-1:0]    dst_q, dst_d;
  logic                rej_q, rej_d;
  logic                cmd_bad;

  logic [NUM_REGS-1:0] oe_n_q, oe_n_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  function automatic logic [NUM_REGS-1:0] sel_dec(input logic [SEL_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_comb begin
    cmd_bad = (bus.req_src == bus.req_dst) ||
              (32'(bus.req_src) >= NUM_REGS) ||
              (32'(bus.req_dst) >= NUM_REGS);
  end

  // Next state; ready_q is high exactly when state_q is StIdle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rej_d   = rej_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          src_d   = bus.req_src;
          dst_d   = bus.req_dst;
          rej_d   = cmd_bad;
          state_d = cmd_bad ? StDone : StDrive;
        end
      end
      StDrive: state_d = StLoad;
      StLoad:  state_d = StHold;
      StHold:  state_d = StDone;
`ifdef NBC_TURNAROUND_EN
      StDone:  state_d = StGap;
`else
      StDone:  state_d = StIdle;
`endif
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    oe_n_d  = '1;
    load_d  = '0;
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    err_d   = (state_d == StDone) && rej_d;
    if (state_d == StDrive || state_d == StLoad || state_d == StHold) begin
      oe_n_d = ~sel_dec(src_d);
    end
    if (state_d == StLoad) begin
      load_d = sel_dec(dst_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      rej_q   <= 1'b0;
      oe_n_q  <= '1;
      load_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rej_q   <= rej_d;
      oe_n_q  <= oe_n_d;
      load_q  <= load_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.out_en_n  = oe_n_q;
  assign bus.load      = load_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Bus safety: single driver, and a strobe only while some other register drives.
  a_one_driver: assert property (@(posedge clk) disable iff (reset) $onehot0(~oe_n_q));
  a_load_driven: assert property (@(posedge clk) disable iff (reset)
    (load_q == '0) || ($onehot(load_q) && $onehot(~oe_n_q)));
  a_no_self_load: assert property (@(posedge clk) disable iff (reset)
    (load_q & ~oe_n_q) == '0);

endmodule
